decoder_stream: RTL and testbench

//  Parametrised, registered IN_W-to-OUT_W decoder with valid/ready streaming on input and output.

---
 rtl/dec_pkg.sv | 45 ++++
 rtl/dec_skid_buf.sv | 60 ++++++
 rtl/decoder_stream.sv | 65 ++++++
 tb/tb_decoder_stream.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// dec_pkg: shared types and the decode function for decoder_stream.
// The decode function works on a fixed maximum width so it does not depend on
// module parameters; callers slice off the OUT_W bits they need.
package dec_pkg;

    typedef enum logic [1:0] {
        DEC_ONEHOT   = 2'b00,
        DEC_THERMO   = 2'b01,
        DEC_ONEHOT_N = 2'b10,
        DEC_RSVD     = 2'b11
    } dec_mode_e;

    localparam int unsigned DEC_SEL_MAX = 6;                 // widest legal select
    localparam int unsigned DEC_MAX_W   = 1 << DEC_SEL_MAX;  // widest legal output

    // Legal configuration: 1 <= in_w <= 6 and 2 <= out_w <= 2**in_w.
    function automatic bit dec_cfg_ok(input int unsigned in_w, input int unsigned out_w);
        return (in_w >= 1) && (in_w <= DEC_SEL_MAX) && (out_w >= 2) && (out_w <= (1 << in_w));
    endfunction

    // Returns {err, y}. Out-of-range select or reserved mode forces y to zero.
    function automatic logic [DEC_MAX_W:0] dec_word(input logic [DEC_SEL_MAX-1:0] sel,
                                                    input dec_mode_e mode,
                                                    input int unsigned out_w);
        logic [DEC_MAX_W-1:0] y;
        logic                 err;
        int unsigned          s;
        s   = 32'(sel);
        y   = '0;
        err = (s >= out_w) || (mode == DEC_RSVD);
        for (int unsigned i = 0; i < DEC_MAX_W; i++) begin
            if (i < out_w) begin
                case (mode)
                    DEC_ONEHOT:   y[i] = (i == s);
                    DEC_THERMO:   y[i] = (i <= s);
                    DEC_ONEHOT_N: y[i] = (i != s);
                    default:      y[i] = 1'b0;
                endcase
            end
        end
        if (err) y = '0;
        return {err, y};
    endfunction

endpackage

// File: rtl/dec_skid_buf.sv
// dec_skid_buf: W-bit valid/ready register with one skid entry behind it.
// in_ready is registered (no combinational path from out_ready); it drops the
// cycle after the skid entry fills.
module dec_skid_buf #(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         skid_valid;
    logic [W-1:0] skid_data;
    logic         acc;
    logic         out_free;

    assign acc      = in_valid && in_ready;
    assign out_free = !out_valid || out_ready;

    // Output register refills from skid first (FIFO order), then from the input.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            in_ready   <= 1'b0;
        end else begin
            if (out_free) begin
                if (skid_valid) begin
                    out_valid <= 1'b1;
                    out_data  <= skid_data;
                    if (acc) begin
                        skid_data <= in_data;
                    end else begin
                        skid_valid <= 1'b0;
                    end
                    in_ready <= !acc;
                end else begin
                    out_valid <= acc;
                    if (acc) out_data <= in_data;
                    in_ready <= 1'b1;
                end
            end else begin
                // Output stalled: an accepted beat parks in the (empty) skid.
                if (acc) begin
                    skid_valid <= 1'b1;
                    skid_data  <= in_data;
                end
                in_ready <= !(acc || skid_valid);
            end
        end
    end

endmodule

// File: rtl/decoder_stream.sv
// decoder_stream: registered IN_W-to-OUT_W decoder (one-hot / thermometer /
// inverted one-hot) with valid/ready streaming and a 2-entry skid buffer.
// Optional feature: define DEC_PARITY_EN to add port par (even parity over
// {mode,sel}); a mismatching beat is emitted as y=0, err=1.
module decoder_stream
    import dec_pkg::*;
#(
    parameter int unsigned IN_W  = 3,
    parameter int unsigned OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  sel,
    input  logic [1:0]       mode,
`ifdef DEC_PARITY_EN
    input  logic             par,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] y,
    output logic             err
);

    localparam bit CFG_OK = dec_cfg_ok(IN_W, OUT_W);

    generate
        if (!CFG_OK) begin : g_bad_cfg
            $error("decoder_stream: illegal IN_W/OUT_W combination");
        end
    endgenerate

    logic [DEC_MAX_W:0] word;
    logic [OUT_W-1:0]   dec_y;
    logic               dec_err;
    logic               unused_word;

    assign word        = dec_word(DEC_SEL_MAX'(sel), dec_mode_e'(mode), OUT_W);
    assign unused_word = ^word;

    // Pick the OUT_W live bits of the decode and apply the optional parity check.
    always_comb begin
        dec_y   = word[OUT_W-1:0];
        dec_err = word[DEC_MAX_W];
`ifdef DEC_PARITY_EN
        if (par != ^{mode, sel}) begin
            dec_y   = '0;
            dec_err = 1'b1;
        end
`endif
    end

    dec_skid_buf #(.W(OUT_W + 1)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({dec_err, dec_y}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  ({err, y})
    );

endmodule

// File: tb/tb_decoder_stream.sv
// tb_decoder_stream: directed vectors against two instances (OUT_W=8 and 6)
// sharing the same stimulus. Inputs change 1ns after the rising edge, outputs
// are sampled at that same point, i.e. after the edge has settled.
module tb_decoder_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [2:0] sel;
    logic [1:0] mode;
    logic       par;
    logic       out_ready;

    logic       in_ready8, out_valid8, err8;
    logic [7:0] y8;
    logic       in_ready6, out_valid6, err6;
    logic [5:0] y6;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    decoder_stream #(.IN_W(3), .OUT_W(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready8),
        .sel       (sel),
        .mode      (mode),
`ifdef DEC_PARITY_EN
        .par       (par),
`endif
        .out_valid (out_valid8),
        .out_ready (out_ready),
        .y         (y8),
        .err       (err8)
    );

    decoder_stream #(.IN_W(3), .OUT_W(6)) u_dut6 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready6),
        .sel       (sel),
        .mode      (mode),
`ifdef DEC_PARITY_EN
        .par       (par),
`endif
        .out_valid (out_valid6),
        .out_ready (out_ready),
        .y         (y6),
        .err       (err6)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one beat with correct parity.
    task automatic drive(input logic [2:0] s, input logic [1:0] m);
        in_valid = 1'b1;
        sel      = s;
        mode     = m;
        par      = ^{m, s};
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; sel = '0; mode = '0; par = 1'b0; out_ready = 1'b1;

        // Reset held 3 cycles with in_valid high
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_out_valid", 32'(out_valid8), 32'd0);
            chk("rst_y",         32'(y8),         32'd0);
            chk("rst_in_ready",  32'(in_ready8),  32'd0);
        end
        rst = 1'b0; in_valid = 1'b0;
        step();
        chk("rel_in_ready",  32'(in_ready8),  32'd1);
        chk("rel_out_valid", 32'(out_valid8), 32'd0);

        // ONEHOT sel=0..7 back-to-back, one result per cycle
        for (int s = 0; s < 8; s++) begin
            drive(3'(s), 2'b00);
            step();
            chk("oh_valid", 32'(out_valid8), 32'd1);
            chk("oh_y",     32'(y8),         32'd1 << s);
            chk("oh_err",   32'(err8),       32'd0);
            chk("oh_rdy",   32'(in_ready8),  32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("oh_drain", 32'(out_valid8), 32'd0);

        // THERMO sel=3
        drive(3'd3, 2'b01); step(); in_valid = 1'b0;
        chk("thermo_y",   32'(y8),   32'h0F);
        chk("thermo_err", 32'(err8), 32'd0);
        chk("thermo6_y",  32'(y6),   32'h0F);
        // ONEHOT_N sel=5
        drive(3'd5, 2'b10); step(); in_valid = 1'b0;
        chk("ohn_y",   32'(y8),   32'hDF);
        chk("ohn_err", 32'(err8), 32'd0);
        // Reserved mode
        drive(3'd2, 2'b11); step(); in_valid = 1'b0;
        chk("rsvd_y",   32'(y8),   32'h00);
        chk("rsvd_err", 32'(err8), 32'd1);

        // OUT_W=6 range check
        drive(3'd6, 2'b00); step(); in_valid = 1'b0;
        chk("w6_oor_y",   32'(y6),   32'h00);
        chk("w6_oor_err", 32'(err6), 32'd1);
        chk("w8_in_rng",  32'(y8),   32'h40);
        drive(3'd5, 2'b00); step(); in_valid = 1'b0;
        chk("w6_top_y",   32'(y6),   32'h20);
        chk("w6_top_err", 32'(err6), 32'd0);
        drive(3'd7, 2'b01); step(); in_valid = 1'b0;
        chk("w6_thermo_oor", 32'({err6, y6}), 32'h40);
        step();
        chk("w6_drain", 32'(out_valid6), 32'd0);

        // Back-pressure: A=1, B=2 accepted, C=3 refused until drain
        out_ready = 1'b0;
        drive(3'd1, 2'b00); step();
        chk("bp_a_y",   32'(y8),        32'h02);
        chk("bp_a_rdy", 32'(in_ready8), 32'd1);
        drive(3'd2, 2'b00); step();
        chk("bp_b_rdy", 32'(in_ready8), 32'd0);
        chk("bp_hold1", 32'(y8),        32'h02);
        drive(3'd3, 2'b00); step();
        chk("bp_hold2", 32'(y8),        32'h02);
        chk("bp_hold_v",32'(out_valid8),32'd1);
        chk("bp_c_rdy", 32'(in_ready8), 32'd0);
        out_ready = 1'b1;
        step();
        chk("bp_out_b", 32'(y8),        32'h04);
        chk("bp_rdy_up",32'(in_ready8), 32'd1);
        step(); in_valid = 1'b0;
        chk("bp_out_c", 32'(y8),        32'h08);
        chk("bp_c_v",   32'(out_valid8),32'd1);
        step();
        chk("bp_empty", 32'(out_valid8),32'd0);

        // Reset mid-transfer drops held beats
        out_ready = 1'b0;
        drive(3'd4, 2'b00); step(); drive(3'd6, 2'b00); step();
        in_valid = 1'b0; rst = 1'b1; step();
        rst = 1'b0; out_ready = 1'b1; step();
        chk("rst_drop_v", 32'(out_valid8), 32'd0);
        chk("rst_drop_y", 32'(y8),         32'd0);

`ifdef DEC_PARITY_EN
        drive(3'd2, 2'b00); par = ~par; step(); in_valid = 1'b0;
        chk("par_bad", 32'({err8, y8}), 32'h100);
        drive(3'd2, 2'b00); step(); in_valid = 1'b0;
        chk("par_ok",  32'({err8, y8}), 32'h004);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
